// File: rtl/ray_delta_seq_if.sv
// ---------------------------------------------------------------------------
// ray_delta_seq_if
//   Request/response bus between ray_delta_seq and the reciprocal unit.
//   Signal names are written from the sequencer's side: o_* leave the
//   sequencer, i_* return to it.
//
//   o_rcp_start  one-cycle request strobe
//   o_rcp_data   operand, held from the request until the matching done
//   o_rcp_abs    asks the unit for |1/x| (tied high by the sequencer)
//   i_rcp_data   reciprocal result
//   i_rcp_sat    result saturated
//   i_rcp_done   result valid strobe
//
//   master : the sequencer
//   slave  : the reciprocal unit
// ---------------------------------------------------------------------------
interface ray_delta_seq_if #(
  parameter int W = 24
) ();

  logic         o_rcp_start;
  logic [W-1:0] o_rcp_data;
  logic         o_rcp_abs;
  logic [W-1:0] i_rcp_data;
  logic         i_rcp_sat;
  logic         i_rcp_done;

  modport master (
    output o_rcp_start, o_rcp_data, o_rcp_abs,
    input  i_rcp_data, i_rcp_sat, i_rcp_done
  );

  modport slave (
    input  o_rcp_start, o_rcp_data, o_rcp_abs,
    output i_rcp_data, i_rcp_sat, i_rcp_done
  );

endinterface

// File: rtl/ray_delta_seq.sv
// ---------------------------------------------------------------------------
// ray_delta_seq
//   Computes the DDA step lengths |1/dir_x| and |1/dir_y| for a ray by
//   issuing two back-to-back requests to an external reciprocal unit.
//   Values are signed two's-complement Qm.n with W = M + N bits.
//
//   A zero direction component never reaches the reciprocal unit: its
//   result is loaded directly with the largest positive value and its
//   saturation flag is set.
//
//   Ports
//     i_clk, i_reset_n        clock, asynchronous active-low reset
//     i_start                 request strobe, only honoured in IDLE
//     i_dir_x, i_dir_y        ray direction, latched on an accepted start
//     o_busy                  high whenever the sequencer is not IDLE
//     o_done                  one-cycle pulse, results valid
//     o_delta_x, o_delta_y    |1/dir| results, held until the next start
//     o_sat_x, o_sat_y        per-result saturation flag
//     o_step_x, o_step_y      sign of the latched direction (1 = negative)
//     o_timeout               (RCP_TIMEOUT_EN only) sticky watchdog flag
//     rcp                     reciprocal unit bus (ray_delta_seq_if.master)
//
//   Build option
//     RCP_TIMEOUT_EN  adds an 8-bit wait counter. After 255 WAIT cycles
//                     without i_rcp_done the pending result is loaded as
//                     saturated, o_timeout is set and sequencing resumes.
//                     Without it, the WAIT states wait indefinitely.
// ---------------------------------------------------------------------------
module ray_delta_seq #(
  parameter  int M = 12,
  parameter  int N = 12,
  localparam int W = M + N
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dir_x,
  input  logic [W-1:0] i_dir_y,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_delta_x,
  output logic [W-1:0] o_delta_y,
  output logic         o_sat_x,
  output logic         o_sat_y,
  output logic         o_step_x,
  output logic         o_step_y,
`ifdef RCP_TIMEOUT_EN
  output logic         o_timeout,
`endif
  ray_delta_seq_if.master rcp
);

  // Largest positive value: 0 followed by W-1 ones.
  localparam logic [W-1:0] SAT_VAL = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    REQ_X,
    WAIT_X,
    REQ_Y,
    WAIT_Y,
    DONE
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] dir_x_q, dir_y_q;

  logic accept;       // start accepted this cycle
  logic timeout_hit;  // watchdog expired this cycle (constant 0 if absent)
  logic wait_end;     // pending reciprocal resolved (done or watchdog)
  logic cap_x, cap_y; // load the X / Y result this cycle

  assign accept   = (state_q == IDLE) && i_start;
  assign wait_end = rcp.i_rcp_done || timeout_hit;
  assign cap_x    = (state_q == WAIT_X) && wait_end;
  assign cap_y    = (state_q == WAIT_Y) && wait_end;

  assign rcp.o_rcp_abs = 1'b1;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and Moore-style outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d         = state_q;
    o_busy          = (state_q != IDLE);
    o_done          = 1'b0;
    rcp.o_rcp_start = 1'b0;
    rcp.o_rcp_data  = '0;

    unique case (state_q)
      IDLE: begin
        // Zero components bypass the reciprocal unit entirely.
        if (i_start) begin
          if (i_dir_x != '0) begin
            state_d = REQ_X;
          end else if (i_dir_y != '0) begin
            state_d = REQ_Y;
          end else begin
            state_d = DONE;
          end
        end
      end

      REQ_X: begin
        rcp.o_rcp_start = 1'b1;
        rcp.o_rcp_data  = dir_x_q;
        state_d         = WAIT_X;
      end

      WAIT_X: begin
        // Operand stays on the bus until the unit answers.
        rcp.o_rcp_data = dir_x_q;
        if (wait_end) begin
          state_d = (dir_y_q != '0) ? REQ_Y : DONE;
        end
      end

      REQ_Y: begin
        rcp.o_rcp_start = 1'b1;
        rcp.o_rcp_data  = dir_y_q;
        state_d         = WAIT_Y;
      end

      WAIT_Y: begin
        rcp.o_rcp_data = dir_y_q;
        if (wait_end) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // i_start is not looked at here; it is honoured on the next IDLE.
        o_done  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand latches and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: there is no memory array here, so every datapath register
      // is reset; a reset mid-operation must leave all outputs at 0.
      dir_x_q   <= '0;
      dir_y_q   <= '0;
      o_step_x  <= 1'b0;
      o_step_y  <= 1'b0;
      o_delta_x <= '0;
      o_delta_y <= '0;
      o_sat_x   <= 1'b0;
      o_sat_y   <= 1'b0;
    end else begin
      if (accept) begin
        dir_x_q   <= i_dir_x;
        dir_y_q   <= i_dir_y;
        o_step_x  <= i_dir_x[W-1];
        o_step_y  <= i_dir_y[W-1];
        // Zero components are final right away; the others are cleared
        // and filled in when their reciprocal returns.
        o_delta_x <= (i_dir_x == '0) ? SAT_VAL : '0;
        o_sat_x   <= (i_dir_x == '0);
        o_delta_y <= (i_dir_y == '0) ? SAT_VAL : '0;
        o_sat_y   <= (i_dir_y == '0);
      end

      // A real answer wins over a watchdog expiry in the same cycle.
      if (cap_x) begin
        o_delta_x <= rcp.i_rcp_done ? rcp.i_rcp_data : SAT_VAL;
        o_sat_x   <= rcp.i_rcp_done ? rcp.i_rcp_sat  : 1'b1;
      end

      if (cap_y) begin
        o_delta_y <= rcp.i_rcp_done ? rcp.i_rcp_data : SAT_VAL;
        o_sat_y   <= rcp.i_rcp_done ? rcp.i_rcp_sat  : 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional reciprocal watchdog
  // -------------------------------------------------------------------------
`ifdef RCP_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       in_wait;

  assign in_wait = (state_q == WAIT_X) || (state_q == WAIT_Y);

  // wait_cnt_q holds the number of WAIT cycles already spent, so the
  // value 254 marks the 255th cycle without an answer.
  assign timeout_hit = in_wait && !rcp.i_rcp_done && (wait_cnt_q == 8'd254);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt_q <= '0;
    end else if (!in_wait) begin
      wait_cnt_q <= '0;
    end else if (!rcp.i_rcp_done) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_timeout <= 1'b0;
    end else if (accept) begin
      o_timeout <= 1'b0;
    end else if (timeout_hit) begin
      o_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
